sliding_window_fp: RTL and testbench
====================================

SLIDING_WINDOW_FP -- requirements
Module: sliding_window_fp

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 5: exponent bits of the floating-point pixel.
REQ-002 SHALL have parameter FRAC_WIDTH, default 10: fraction bits; pixel width FP_WIDTH_REG = 1+EXP_WIDTH+FRAC_WIDTH.
REQ-003 SHALL have parameters WINDOW_WIDTH and WINDOW_HEIGHT, defaults 5 and 5: window size, odd, 3..9.
REQ-004 SHALL have parameters IMAGE_WIDTH and IMAGE_HEIGHT, defaults 640 and 480: frame size in pixels, 16..65535.
REQ-005 SHALL have ports clk_i (in, 1, sole clock) and rst_i (in, 1, asynchronous active-low reset).
REQ-006 SHALL have ports pixel_i (in, FP_WIDTH_REG, raster pixel), col_i (in, 16, pixel column) and row_i (in, 16, pixel row).
REQ-007 SHALL have port valid_i (in, 1, pixel accepted on the rising edge when high; no backpressure).
REQ-008 SHALL have port window_o (out, FP_WIDTH_REG x [WINDOW_HEIGHT][WINDOW_WIDTH]); [0][0] is oldest row and column.
REQ-009 SHALL have ports col_o and row_o (out, 16 each, coordinates of the window centre) and valid_o (out, 1).
REQ-010 SHALL have port err_o (out, 1, sticky coordinate mismatch flag).

Function
REQ-011 SHALL keep internal raster counters col_cnt/row_cnt, advanced once per accepted pixel; col wraps at IMAGE_WIDTH-1 and increments row; row wraps at IMAGE_HEIGHT-1 to 0.
REQ-012 SHALL hold WINDOW_HEIGHT-1 line buffers of IMAGE_WIDTH entries, addressed by col_cnt, chained so that buffer k holds row row_cnt-k-1.
REQ-013 SHALL hold WINDOW_HEIGHT shift registers of WINDOW_WIDTH taps, shifted only on an accepted pixel.
REQ-014 SHALL, one cycle after accepting pixel (r,c), present rows r-WINDOW_HEIGHT+1..r and columns c-WINDOW_WIDTH+1..c on window_o.
REQ-015 SHALL drive col_o = c-(WINDOW_WIDTH-1)/2 and row_o = r-(WINDOW_HEIGHT-1)/2 alongside that window.
REQ-016 SHALL assert valid_o for exactly one cycle only when c >= WINDOW_WIDTH-1 and r >= WINDOW_HEIGHT-1; windows straddling a row or frame wrap are never valid.
REQ-017 SHALL hold window_o, col_o and row_o unchanged and deassert valid_o in cycles with valid_i low.
REQ-018 SHALL sustain one pixel per cycle with no bubbles, including across row and frame wraps.
REQ-019 SHALL pass pixel bits unmodified (no arithmetic on floating-point values).

Reset
REQ-020 SHALL on rst_i low clear col_cnt, row_cnt, shift registers, window_o, col_o, row_o, valid_o and err_o to 0, asynchronously.
REQ-021 SHALL leave line-buffer contents unreset; REQ-016 guarantees stale data is never flagged valid.
REQ-022 SHALL treat the first pixel after a mid-frame reset as (0,0).

Configuration
REQ-023 SHALL, with COORD_CHECK_EN defined, compare col_i/row_i to col_cnt/row_cnt on each accepted pixel.
REQ-024 SHALL, under COORD_CHECK_EN, on mismatch set err_o (sticky until reset) and resynchronise counters to col_i+1/row_i (with wrap) for the next pixel.
REQ-025 SHALL, without COORD_CHECK_EN, ignore col_i/row_i and tie err_o to 0.

Structure
REQ-026 SHALL place FP_WIDTH_REG derivation, window typedef and coordinate width (16) in shared package sliding_window_pkg.
REQ-027 SHALL implement one line buffer as sub-module line_buffer_fp (single write/read port, synchronous, depth IMAGE_WIDTH), instantiated WINDOW_HEIGHT-1 times.

Verification (IMAGE_WIDTH=8, IMAGE_HEIGHT=6, 5x5, pixel = fp16 of index r*8+c)
REQ-028 SHALL check: full frame, valid_i always high -> exactly 4x2=8 valid_o pulses, first after pixel (4,4) with col_o=2,row_o=2, window_o[0][0]=0.0, [4][4]=36.0.
REQ-029 SHALL check: valid_i toggling 1/0 -> same 8 windows, outputs held in gap cycles, valid_o never high in gaps.
REQ-030 SHALL check: two back-to-back frames -> no valid_o for rows 0..3 of frame 2, second frame windows identical to first.
REQ-031 SHALL check: rst_i low at pixel (3,5) then restart -> all outputs 0 during reset, next valid_o after 37 more accepted pixels.
REQ-032 SHALL check (COORD_CHECK_EN): pixel (2,3) sent as (2,4) -> err_o high next cycle and held, counters resynced to (2,5).
REQ-033 SHALL check (no COORD_CHECK_EN): same stimulus -> err_o stays 0, counters unaffected.

Source files
------------

// File: rtl/sliding_window_pkg.sv
// Shared types and widths for the floating-point sliding-window generator.
package sliding_window_pkg;

    localparam int unsigned COORD_WIDTH = 16;

    typedef logic [COORD_WIDTH-1:0] coord_t;

    function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    // Window shape for the default geometry (fp16 pixels, 5x5).
    localparam int unsigned DEFAULT_FP_WIDTH = fp_width(5, 10);
    typedef logic [DEFAULT_FP_WIDTH-1:0] fp_pixel_t;
    typedef fp_pixel_t window_t [5][5];

endpackage

// File: rtl/line_buffer_fp.sv
// One image line of pixel storage: synchronous write, read of the same address in the same cycle
// so the previous row's pixel is visible while the current one is being written.
module line_buffer_fp #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 640,
    localparam int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; stale data is never flagged valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/sliding_window_fp.sv
// Raster-to-window generator for floating-point pixels; pixel bits pass through untouched.
// Optional COORD_CHECK_EN macro enables input coordinate checking and counter resync.
module sliding_window_fp
    import sliding_window_pkg::*;
#(
    parameter int unsigned EXP_WIDTH     = 5,
    parameter int unsigned FRAC_WIDTH    = 10,
    parameter int unsigned WINDOW_WIDTH  = 5,
    parameter int unsigned WINDOW_HEIGHT = 5,
    parameter int unsigned IMAGE_WIDTH   = 640,
    parameter int unsigned IMAGE_HEIGHT  = 480,
    localparam int unsigned FP_WIDTH_REG = fp_width(EXP_WIDTH, FRAC_WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] pixel_i,
    input  logic [COORD_WIDTH-1:0]  col_i,
    input  logic [COORD_WIDTH-1:0]  row_i,
    input  logic                    valid_i,
    output logic [FP_WIDTH_REG-1:0] window_o [WINDOW_HEIGHT][WINDOW_WIDTH],
    output logic [COORD_WIDTH-1:0]  col_o,
    output logic [COORD_WIDTH-1:0]  row_o,
    output logic                    valid_o,
    output logic                    err_o
);

    localparam int unsigned ADDR_WIDTH = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int unsigned NUM_LINES  = WINDOW_HEIGHT - 1;
    localparam coord_t COL_LAST = coord_t'(IMAGE_WIDTH - 1);
    localparam coord_t ROW_LAST = coord_t'(IMAGE_HEIGHT - 1);
    localparam coord_t COL_MIN  = coord_t'(WINDOW_WIDTH - 1);
    localparam coord_t ROW_MIN  = coord_t'(WINDOW_HEIGHT - 1);
    localparam coord_t HALF_W   = coord_t'((WINDOW_WIDTH - 1) / 2);
    localparam coord_t HALF_H   = coord_t'((WINDOW_HEIGHT - 1) / 2);
    localparam coord_t ONE      = coord_t'(1);

    coord_t col_cnt, row_cnt;
    coord_t col_base, row_base;
    coord_t col_nxt, row_nxt;
    logic   mismatch;

    logic [FP_WIDTH_REG-1:0] line_in  [NUM_LINES];
    logic [FP_WIDTH_REG-1:0] line_out [NUM_LINES];
    // Column entering the window; index WINDOW_HEIGHT-1 is the newest row.
    logic [FP_WIDTH_REG-1:0] column   [WINDOW_HEIGHT];
    logic [ADDR_WIDTH-1:0]   addr;

    assign addr = col_cnt[ADDR_WIDTH-1:0];
    assign column[WINDOW_HEIGHT-1] = pixel_i;

    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        if (k == 0) begin : g_head
            assign line_in[k] = pixel_i;
        end else begin : g_chain
            assign line_in[k] = line_out[k-1];
        end
        assign column[NUM_LINES-1-k] = line_out[k];

        line_buffer_fp #(
            .WIDTH (FP_WIDTH_REG),
            .DEPTH (IMAGE_WIDTH)
        ) u_line (
            .clk     (clk_i),
            .wr_en   (valid_i),
            .addr    (addr),
            .wr_data (line_in[k]),
            .rd_data (line_out[k])
        );
    end

`ifdef COORD_CHECK_EN
    assign mismatch = valid_i && ((col_i != col_cnt) || (row_i != row_cnt));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_o <= 1'b0;
        end else if (mismatch) begin
            err_o <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
    assign err_o    = 1'b0;
`endif

    // On a coordinate mismatch the next pixel follows the upstream's claimed position.
    always_comb begin
        col_base = mismatch ? col_i : col_cnt;
        row_base = mismatch ? row_i : row_cnt;
        col_nxt  = col_base + ONE;
        row_nxt  = row_base;
        if (col_base >= COL_LAST) begin
            col_nxt = '0;
            row_nxt = (row_base >= ROW_LAST) ? '0 : row_base + ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            col_cnt <= '0;
            row_cnt <= '0;
            col_o   <= '0;
            row_o   <= '0;
            valid_o <= 1'b0;
            for (int i = 0; i < WINDOW_HEIGHT; i++) begin
                for (int j = 0; j < WINDOW_WIDTH; j++) begin
                    window_o[i][j] <= '0;
                end
            end
        end else begin
            valid_o <= 1'b0;
            if (valid_i) begin
                col_cnt <= col_nxt;
                row_cnt <= row_nxt;
                col_o   <= col_cnt - HALF_W;
                row_o   <= row_cnt - HALF_H;
                valid_o <= (col_cnt >= COL_MIN) && (row_cnt >= ROW_MIN);
                for (int i = 0; i < WINDOW_HEIGHT; i++) begin
                    for (int j = 0; j < WINDOW_WIDTH - 1; j++) begin
                        window_o[i][j] <= window_o[i][j+1];
                    end
                    window_o[i][WINDOW_WIDTH-1] <= column[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_fp.sv
// Randomized self-checking bench for sliding_window_fp on an 8x6 frame with a 5x5 window.
module tb_sliding_window_fp;
    import sliding_window_pkg::*;

    localparam int IW = 8;
    localparam int IH = 6;
    localparam int WW = 5;
    localparam int WH = 5;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [15:0] pixel_i = '0;
    coord_t      col_i = '0;
    coord_t      row_i = '0;
    logic [15:0] window_o [WH][WW];
    coord_t      col_o, row_o;
    logic        valid_o, err_o;

    always #5 clk = ~clk;

    sliding_window_fp #(
        .EXP_WIDTH     (5),
        .FRAC_WIDTH    (10),
        .WINDOW_WIDTH  (WW),
        .WINDOW_HEIGHT (WH),
        .IMAGE_WIDTH   (IW),
        .IMAGE_HEIGHT  (IH)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .pixel_i  (pixel_i),
        .col_i    (col_i),
        .row_i    (row_i),
        .valid_i  (valid_i),
        .window_o (window_o),
        .col_o    (col_o),
        .row_o    (row_o),
        .valid_o  (valid_o),
        .err_o    (err_o)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: raster position of the next pixel and the image as written so far.
    int          mr, mc;
    logic [15:0] img [IH][IW];
    bit          exp_valid;
    bit          win_defined;
    int          exp_c, exp_r;
    window_t     exp_win;
    int          bad_i, bad_j;

    function automatic logic [15:0] fp16(input int n);
        int e;
        if (n == 0) return 16'h0000;
        e = 0;
        while ((1 << (e + 1)) <= n) e++;
        return {1'b0, 5'(e + 15), 10'((n - (1 << e)) << (10 - e))};
    endfunction

    function automatic bit win_match();
        for (int i = 0; i < WH; i++) begin
            for (int j = 0; j < WW; j++) begin
                if (window_o[i][j] !== exp_win[i][j]) begin
                    bad_i = i;
                    bad_j = j;
                    return 1'b0;
                end
            end
        end
        return 1'b1;
    endfunction

    function automatic bit win_zero();
        for (int i = 0; i < WH; i++)
            for (int j = 0; j < WW; j++)
                if (window_o[i][j] !== 16'h0000) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        mr = 0; mc = 0; exp_valid = 0; win_defined = 0; exp_c = 0; exp_r = 0;
    endtask

    task automatic step(input bit v, input logic [15:0] pix, input int ci, input int ri);
        int r, c, bc, br;
        valid_i = v; pixel_i = pix; col_i = coord_t'(ci); row_i = coord_t'(ri);
        if (v) begin
            r = mr; c = mc;
            img[r][c] = pix;
            exp_c = c - (WW - 1) / 2;
            exp_r = r - (WH - 1) / 2;
            exp_valid = (c >= WW - 1) && (r >= WH - 1);
            win_defined = exp_valid;
            if (exp_valid)
                for (int i = 0; i < WH; i++)
                    for (int j = 0; j < WW; j++)
                        exp_win[i][j] = img[r - WH + 1 + i][c - WW + 1 + j];
            bc = c; br = r;
`ifdef COORD_CHECK_EN
            if (ci != c || ri != r) begin bc = ci; br = ri; end
`endif
            mc = bc + 1; mr = br;
            if (mc >= IW) begin
                mc = 0;
                mr = (br >= IH - 1) ? 0 : br + 1;
            end
        end else begin
            exp_valid = 0;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        valid_i = 1'b0;
        rst_i = 1'b0;
        #3;
        checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_o); else passed++;
        checks++; if (err_o !== 1'b0) $display("FAIL reset_err got %b want 0", err_o); else passed++;
        checks++; if (col_o !== 16'd0 || row_o !== 16'd0)
            $display("FAIL reset_coord got col %0d row %0d want 0 0", col_o, row_o); else passed++;
        checks++; if (!win_zero()) $display("FAIL reset_window got nonzero want all zero"); else passed++;
        @(negedge clk);
        rst_i = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_frame();
        int pulses = 0;
        int first_idx = -1;
        for (int idx = 0; idx < IW * IH; idx++) begin
            step(1, fp16(idx), idx % IW, idx / IW);
            checks++; if (valid_o !== exp_valid)
                $display("FAIL frame_valid idx %0d got %b want %b", idx, valid_o, exp_valid); else passed++;
            if (valid_o) pulses++;
            if (exp_valid) begin
                checks++; if (col_o !== coord_t'(exp_c) || row_o !== coord_t'(exp_r))
                    $display("FAIL frame_coord got (%0d,%0d) want (%0d,%0d)", row_o, col_o, exp_r, exp_c);
                else passed++;
                checks++; if (!win_match())
                    $display("FAIL frame_window [%0d][%0d] got %h want %h", bad_i, bad_j,
                             window_o[bad_i][bad_j], exp_win[bad_i][bad_j]);
                else passed++;
                if (first_idx < 0) begin
                    first_idx = idx;
                    checks++; if (window_o[0][0] !== 16'h0000 || window_o[4][4] !== 16'h5080)
                        $display("FAIL first_window corners got %h %h want 0000 5080",
                                 window_o[0][0], window_o[4][4]);
                    else passed++;
                    checks++; if (col_o !== 16'd2 || row_o !== 16'd2)
                        $display("FAIL first_centre got (%0d,%0d) want (2,2)", row_o, col_o);
                    else passed++;
                end
            end
        end
        checks++; if (pulses != 8) $display("FAIL frame_pulses got %0d want 8", pulses); else passed++;
        checks++; if (first_idx != 36) $display("FAIL first_pulse_idx got %0d want 36", first_idx);
        else passed++;
    endtask

    task automatic test_toggle();
        int pulses = 0;
        for (int idx = 0; idx < IW * IH; idx++) begin
            step(1, 16'($urandom), idx % IW, idx / IW);
            checks++; if (valid_o !== exp_valid)
                $display("FAIL toggle_valid idx %0d got %b want %b", idx, valid_o, exp_valid); else passed++;
            if (valid_o) pulses++;
            if (exp_valid) begin
                checks++; if (!win_match())
                    $display("FAIL toggle_window [%0d][%0d] got %h want %h", bad_i, bad_j,
                             window_o[bad_i][bad_j], exp_win[bad_i][bad_j]);
                else passed++;
            end
            step(0, 16'($urandom), 0, 0);
            checks++; if (valid_o !== 1'b0) $display("FAIL gap_valid idx %0d got %b want 0", idx, valid_o);
            else passed++;
            checks++; if (col_o !== coord_t'(exp_c) || row_o !== coord_t'(exp_r))
                $display("FAIL gap_coord got (%0d,%0d) want (%0d,%0d)", row_o, col_o,
                         coord_t'(exp_r), coord_t'(exp_c));
            else passed++;
            if (win_defined) begin
                checks++; if (!win_match())
                    $display("FAIL gap_window [%0d][%0d] got %h want %h", bad_i, bad_j,
                             window_o[bad_i][bad_j], exp_win[bad_i][bad_j]);
                else passed++;
            end
        end
        checks++; if (pulses != 8) $display("FAIL toggle_pulses got %0d want 8", pulses); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] frame [IH * IW];
        int pulses [2];
        int early = 0;
        for (int idx = 0; idx < IW * IH; idx++) frame[idx] = 16'($urandom);
        for (int f = 0; f < 2; f++) begin
            pulses[f] = 0;
            for (int idx = 0; idx < IW * IH; idx++) begin
                step(1, frame[idx], idx % IW, idx / IW);
                checks++; if (valid_o !== exp_valid)
                    $display("FAIL b2b_valid f%0d idx %0d got %b want %b", f, idx, valid_o, exp_valid);
                else passed++;
                if (valid_o) pulses[f]++;
                if (valid_o && f == 1 && idx / IW < 4) early++;
                if (exp_valid) begin
                    checks++; if (!win_match())
                        $display("FAIL b2b_window [%0d][%0d] got %h want %h", bad_i, bad_j,
                                 window_o[bad_i][bad_j], exp_win[bad_i][bad_j]);
                    else passed++;
                end
            end
            checks++; if (pulses[f] != 8) $display("FAIL b2b_pulses f%0d got %0d want 8", f, pulses[f]);
            else passed++;
        end
        checks++; if (early != 0) $display("FAIL b2b_early got %0d want 0", early); else passed++;
    endtask

    task automatic test_reset_mid();
        int count = 0;
        bit seen = 0;
        for (int idx = 0; idx < 3 * IW + 5; idx++) step(1, 16'($urandom), idx % IW, idx / IW);
        valid_i = 1'b1; pixel_i = 16'($urandom); col_i = 16'd5; row_i = 16'd3;
        #2;
        rst_i = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || err_o !== 1'b0 || col_o !== 16'd0 || row_o !== 16'd0 || !win_zero())
            $display("FAIL midreset_async got valid %b err %b col %0d row %0d want all 0",
                     valid_o, err_o, col_o, row_o);
        else passed++;
        @(posedge clk);
        #1;
        checks++; if (valid_o !== 1'b0 || col_o !== 16'd0 || row_o !== 16'd0 || !win_zero())
            $display("FAIL midreset_held got valid %b col %0d row %0d want all 0", valid_o, col_o, row_o);
        else passed++;
        valid_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        model_reset();
        while (!seen && count < 60) begin
            step(1, 16'($urandom), mc, mr);
            count++;
            if (valid_o) seen = 1;
        end
        checks++; if (count != 37 || !seen)
            $display("FAIL midreset_latency got %0d pixels want 37", count); else passed++;
        checks++; if (!win_match())
            $display("FAIL midreset_window [%0d][%0d] got %h want %h", bad_i, bad_j,
                     window_o[bad_i][bad_j], exp_win[bad_i][bad_j]);
        else passed++;
    endtask

    task automatic test_coord_err();
        int guard = 0;
        bit exp_err;
`ifdef COORD_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        while (!(mr == 2 && mc == 3) && guard < 100) begin
            step(1, 16'($urandom), mc, mr);
            guard++;
        end
        checks++; if (guard >= 100) $display("FAIL err_reach got timeout want (2,3)"); else passed++;
        checks++; if (err_o !== 1'b0) $display("FAIL err_before got %b want 0", err_o); else passed++;
        step(1, 16'($urandom), 4, 2);
        checks++; if (err_o !== exp_err) $display("FAIL err_set got %b want %b", err_o, exp_err);
        else passed++;
        checks++; if (dut.col_cnt !== coord_t'(mc) || dut.row_cnt !== coord_t'(mr))
            $display("FAIL err_resync got (%0d,%0d) want (%0d,%0d)", dut.row_cnt, dut.col_cnt, mr, mc);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            step(0, 16'h0, 0, 0);
            step(1, 16'($urandom), mc, mr);
            checks++; if (err_o !== exp_err) $display("FAIL err_sticky got %b want %b", err_o, exp_err);
            else passed++;
            checks++; if (valid_o !== exp_valid) $display("FAIL err_valid got %b want %b", valid_o, exp_valid);
            else passed++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_frame();
        test_toggle();
        test_back_to_back();
        test_reset_mid();
        test_coord_err();
        test_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
